// File: rtl/w2m_bridge.sv
// Wishbone classic slave to mem_if initiator bridge: one Wishbone cycle becomes one
// mem_if request, completed with ack or err once the tid-matched response arrives.
module w2m_bridge #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned BUS_MASK  = 4,
    parameter logic [3:0]  RID       = 4'd0,
    parameter logic [3:0]  SRCID     = 4'd0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [BUS_WIDTH-1:0] wb_addr_i,
    input  logic [BUS_WIDTH-1:0] wb_data_i,
    input  logic [BUS_MASK-1:0]  wb_sel_i,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic [BUS_WIDTH-1:0] wb_data_o,
    output logic                 mem_if_req_valid,
    input  logic                 mem_if_req_ready,
    output logic [86:0]          mem_if_req,
    input  logic                 mem_if_resp_valid,
    output logic                 mem_if_resp_ready,
    input  logic [50:0]          mem_if_resp
);
    localparam int unsigned REQ_W  = 87;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned TID_W  = 16;
    localparam int unsigned SEQ_W  = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [TYPE_W-1:0] TYPE_RD  = 3'd0;
    localparam logic [TYPE_W-1:0] TYPE_WR  = 3'd1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t               state, state_n;
    logic [SEQ_W-1:0]     seq, seq_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 ack_n, err_n, req_valid_n;
    logic [BUS_WIDTH-1:0] data_n;
    logic [REQ_W-1:0]     req_n;

    logic [TYPE_W-1:0]    req_type, resp_type;
    logic [TID_W-1:0]     req_tid, resp_tid;
    logic                 tid_hit, timeout_hit;

    assign req_type    = mem_if_req[86:84];
    assign req_tid     = mem_if_req[83:68];
    assign resp_type   = mem_if_resp[50:48];
    assign resp_tid    = mem_if_resp[47:32];
    assign tid_hit     = mem_if_resp_valid && (resp_tid == req_tid);
    assign timeout_hit = (cnt == CNT_LAST);

    // Gated by reset so the port reads 0 while reset is held, even though state is IDLE.
    assign mem_if_resp_ready = !rst_i && ((state == IDLE) || (state == WAIT));

    always_comb begin
        state_n = state;
        seq_n   = seq;
        cnt_n   = cnt;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        data_n  = wb_data_o;
        req_n   = mem_if_req;
        unique case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    req_n   = {(wb_we_i ? TYPE_WR : TYPE_RD), RID, SRCID, seq,
                               wb_addr_i, wb_sel_i, wb_data_i};
                    cnt_n   = '0;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (!wb_cyc_i) begin
                    state_n = IDLE;
                end else if (mem_if_req_ready) begin
                    // An accepted request consumes its tid even if the timeout fires now.
                    seq_n = seq + 1'b1;
                    cnt_n = cnt + 1'b1;
                    if (timeout_hit) begin
                        err_n   = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = WAIT;
                    end
                end else if (timeout_hit) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_n = IDLE;
                end else if (tid_hit) begin
                    if (resp_type == req_type) begin
                        ack_n = 1'b1;
                        if (req_type == TYPE_RD) data_n = mem_if_resp[31:0];
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = DONE;
                end else if (timeout_hit) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        req_valid_n = (state_n == REQ);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            seq              <= '0;
            cnt              <= '0;
            wb_ack_o         <= 1'b0;
            wb_err_o         <= 1'b0;
            wb_data_o        <= '0;
            mem_if_req_valid <= 1'b0;
            mem_if_req       <= '0;
        end else begin
            state            <= state_n;
            seq              <= seq_n;
            cnt              <= cnt_n;
            wb_ack_o         <= ack_n;
            wb_err_o         <= err_n;
            wb_data_o        <= data_n;
            mem_if_req_valid <= req_valid_n;
            mem_if_req       <= req_n;
        end
    end
endmodule

// File: tb/tb_w2m_bridge.sv
// Bench for w2m_bridge: directed scenarios plus randomized transfers against a
// transaction-level model of tid sequencing, completion latency and read data.
module tb_w2m_bridge;
    localparam int          TO    = 8;
    localparam logic [3:0]  RID   = 4'd0;
    localparam logic [3:0]  SRCID = 4'd0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_addr_i, wb_data_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o, wb_err_o;
    logic [31:0] wb_data_o;
    logic        mem_if_req_valid, mem_if_req_ready;
    logic [86:0] mem_if_req;
    logic        mem_if_resp_valid, mem_if_resp_ready;
    logic [50:0] mem_if_resp;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_seq;
    logic [31:0] exp_rdata;

    w2m_bridge #(.BUS_WIDTH(32), .BUS_MASK(4), .RID(RID), .SRCID(SRCID), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_sel_i(wb_sel_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_data_o(wb_data_o),
        .mem_if_req_valid(mem_if_req_valid), .mem_if_req_ready(mem_if_req_ready),
        .mem_if_req(mem_if_req),
        .mem_if_resp_valid(mem_if_resp_valid), .mem_if_resp_ready(mem_if_resp_ready),
        .mem_if_resp(mem_if_resp)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ack"}, 128'(wb_ack_o), 128'd0);
        check_eq({tag, "_err"}, 128'(wb_err_o), 128'd0);
        check_eq({tag, "_rdata"}, 128'(wb_data_o), 128'd0);
        check_eq({tag, "_valid"}, 128'(mem_if_req_valid), 128'd0);
        check_eq({tag, "_req"}, 128'(mem_if_req), 128'd0);
        check_eq({tag, "_resp_ready"}, 128'(mem_if_resp_ready), 128'd0);
    endtask

    // One Wishbone transfer. rs: ready stall cycles (-1 never ready); pd: extra response
    // delay (-1 never respond); bad: a wrong-tid response first; early: a matching
    // response offered in the handshake cycle (must be ignored). Entered #1 after an edge.
    task automatic run_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] sel, input int rs, input int pd, input logic bad,
                            input logic early, input logic [2:0] rtype, input logic [31:0] rdata);
        logic [2:0]  qtype;
        logic [15:0] tid;
        logic [86:0] exp_req;
        logic        ok, hs_done;
        int          rsp, lat, hs;
        qtype   = we ? 3'd1 : 3'd0;
        tid     = {RID, SRCID, exp_seq};
        exp_req = {qtype, tid, addr, sel, wdata};
        hs_done = (rs >= 0);
        if (rs >= 0 && pd >= 0) begin
            rsp = rs + pd + 1 + int'(bad);
            lat = rsp + 1;
            ok  = (rtype == qtype);
        end else begin
            rsp = -1;
            lat = TO;
            ok  = 1'b0;
        end
        hs = hs_done ? rs + 1 : lat;

        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_addr_i = addr; wb_data_i = wdata; wb_sel_i = sel;
        @(posedge clk_i); #1;
        for (int n = 0; n <= lat; n++) begin
            mem_if_req_ready  = hs_done && (n == rs);
            mem_if_resp_valid = 1'b0;
            mem_if_resp       = '0;
            if (early && hs_done && n == rs) begin
                mem_if_resp_valid = 1'b1;
                mem_if_resp       = {qtype, tid, ~rdata};
            end
            if (bad && rsp >= 0 && n == rsp - 1) begin
                mem_if_resp_valid = 1'b1;
                mem_if_resp       = {qtype, tid ^ 16'h0005, 32'hBAD0_0000 ^ rdata};
            end
            if (rsp >= 0 && n == rsp) begin
                mem_if_resp_valid = 1'b1;
                mem_if_resp       = {rtype, tid, rdata};
            end
            @(negedge clk_i);
            check_eq("req_valid", 128'(mem_if_req_valid), 128'(n < hs));
            if (n < hs) check_eq("req_payload", 128'(mem_if_req), 128'(exp_req));
            check_eq("resp_ready", 128'(mem_if_resp_ready), 128'((n >= hs) && (n < lat)));
            if (n == lat && ok && !we) exp_rdata = rdata;
            check_eq("ack", 128'(wb_ack_o), 128'((n == lat) && ok));
            check_eq("err", 128'(wb_err_o), 128'((n == lat) && !ok));
            if (n == lat) check_eq("rdata", 128'(wb_data_o), 128'(exp_rdata));
            @(posedge clk_i); #1;
        end
        // stb was still high at the DONE edge; it must not have started a new transfer
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        mem_if_req_ready = 1'b0; mem_if_resp_valid = 1'b0;
        @(negedge clk_i);
        check_eq("no_restart", 128'(mem_if_req_valid), 128'd0);
        check_eq("pulse_cleared", 128'({wb_ack_o, wb_err_o}), 128'd0);
        @(posedge clk_i); #1;
        if (hs_done) exp_seq = exp_seq + 8'd1;
    endtask

    initial begin
        logic        we;
        logic [2:0]  rtype;
        logic [15:0] old_tid;
        rst_i = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_addr_i = '0; wb_data_i = '0; wb_sel_i = '0;
        mem_if_req_ready = 1'b0; mem_if_resp_valid = 1'b0; mem_if_resp = '0;
        exp_seq = 8'd0; exp_rdata = 32'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_outputs_zero("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // read, then write with 4 stalled ready cycles, then wrong-tid then right-tid
        run_xfer(1'b0, 32'h1000_0040, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 3'd0, 32'hDEAD_BEEF);
        run_xfer(1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 4, 0, 1'b0, 1'b0, 3'd1, 32'h0);
        run_xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 1, 1'b1, 1'b0, 3'd0, 32'hCAFE_F00D);
        // error response type: err and read data unchanged
        run_xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, 0, 1'b0, 1'b1, 3'd2, 32'h5555_AAAA);

        // abort in REQ with ready low: valid drops, no pulse, seq unchanged
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 32'h44;
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk_i);
        check_eq("abort_valid_hi", 128'(mem_if_req_valid), 128'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_eq("abort_valid_lo", 128'(mem_if_req_valid), 128'd0);
        check_eq("abort_pulse", 128'({wb_ack_o, wb_err_o}), 128'd0);
        @(posedge clk_i); #1;

        // timeouts: request never accepted, then accepted but never answered
        run_xfer(1'b1, 32'h0000_0300, 32'h0BAD_0BAD, 4'hF, -1, -1, 1'b0, 1'b0, 3'd1, 32'h0);
        old_tid = {RID, SRCID, exp_seq};
        run_xfer(1'b0, 32'h0000_0400, 32'h0, 4'hF, 0, -1, 1'b0, 1'b0, 3'd0, 32'h0);
        mem_if_resp_valid = 1'b1;
        mem_if_resp = {3'd0, old_tid, 32'h7777_7777};
        @(negedge clk_i);
        check_eq("drain_ready", 128'(mem_if_resp_ready), 128'd1);
        @(posedge clk_i); #1;
        mem_if_resp_valid = 1'b0;
        @(negedge clk_i);
        check_eq("drain_pulse", 128'({wb_ack_o, wb_err_o}), 128'd0);
        check_eq("drain_rdata", 128'(wb_data_o), 128'(exp_rdata));
        @(posedge clk_i); #1;
        run_xfer(1'b0, 32'h0000_0500, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 3'd0, 32'h600D_600D);

        // randomized traffic, long enough to wrap the tid sequence
        for (int i = 0; i < 270; i++) begin
            we    = 1'($urandom);
            rtype = (($urandom % 8) == 0) ? 3'($urandom) : {2'b00, we};
            run_xfer(we, $urandom, $urandom, 4'($urandom),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     (($urandom % 4) == 0), 1'($urandom), rtype, $urandom);
        end

        // reset while waiting for the response
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 32'h88;
        @(posedge clk_i); #1;
        mem_if_req_ready = 1'b1;
        @(posedge clk_i); #1;
        mem_if_req_ready = 1'b0;
        rst_i = 1'b1;
        #1;
        check_outputs_zero("rst_wait");
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_seq = 8'd0; exp_rdata = 32'd0;
        @(posedge clk_i); #1;
        run_xfer(1'b0, 32'h0000_0600, 32'h0, 4'hF, 1, 1, 1'b0, 1'b0, 3'd0, 32'h0123_4567);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
